// File: rtl/wave_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_capture_if
// Brief    : Sample stream, display handshake and sample-RAM write port bundle.
// Revision : 1.0
// ============================================================================
interface wave_capture_if;
   logic        new_sample_ready;
   logic [15:0] new_sample_in;
   logic        wave_display_idle;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;
   logic        capture_done;

   // master drives samples and display status; slave is the capture engine
   modport master (
      output new_sample_ready,
      output new_sample_in,
      output wave_display_idle,
      input  write_address,
      input  write_enable,
      input  write_sample,
      input  read_index,
      input  capture_done
   );

   modport slave (
      input  new_sample_ready,
      input  new_sample_in,
      input  wave_display_idle,
      output write_address,
      output write_enable,
      output write_sample,
      output read_index,
      output capture_done
   );
endinterface
`default_nettype wire

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module   : wave_capture
// Brief    : Captures 256 samples after a positive zero crossing into the
//            bank the display is not reading; swaps banks when display idles.
//            Option macro WAVE_CAPTURE_DECIMATE_EN stores every other strobe.
// Revision : 1.0
// ============================================================================
module wave_capture (
   input  wire logic     clk,
   input  wire logic     reset,
   wave_capture_if.slave bus
);

   localparam logic [1:0] ST_ARMED  = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic [7:0]  r_index;
   logic [15:0] r_prev_sample;
   logic        r_read_index;
   logic        r_write_enable;
   logic [8:0]  r_write_address;
   logic [7:0]  r_write_sample;
   logic        r_capture_done;

   logic        w_trigger;
   logic        w_store;
   logic        w_swap;
   logic        w_store_slot;
   logic [7:0]  w_offset_sample;

`ifdef WAVE_CAPTURE_DECIMATE_EN
   logic        r_phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase <= 1'b0;
      end else if (w_trigger) begin
         r_phase <= 1'b0;
      end else if (r_state == ST_ACTIVE && bus.new_sample_ready) begin
         r_phase <= ~r_phase;
      end
   end

   assign w_store_slot = ~r_phase;
`else
   assign w_store_slot = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_ARMED;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ARMED: begin
            if (w_trigger) w_state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (w_store && r_index == 8'hFF) w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.wave_display_idle) w_state_next = ST_ARMED;
         end
         default: begin
            w_state_next = ST_ARMED;
         end
      endcase
   end

   always_comb begin
      w_trigger       = 1'b0;
      w_store         = 1'b0;
      w_swap          = 1'b0;
      // sign-bit inversion maps two's complement onto offset binary
      w_offset_sample = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
      case (r_state)
         ST_ARMED: begin
            w_trigger = bus.new_sample_ready & r_prev_sample[15]
                        & ~bus.new_sample_in[15];
         end
         ST_ACTIVE: begin
            w_store = bus.new_sample_ready & w_store_slot;
         end
         ST_WAIT: begin
            w_swap = bus.wave_display_idle;
         end
         default: begin
            w_trigger = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_index         <= 8'd0;
         r_prev_sample   <= 16'd0;
         r_read_index    <= 1'b0;
         r_write_enable  <= 1'b0;
         r_write_address <= 9'd0;
         r_write_sample  <= 8'd0;
         r_capture_done  <= 1'b0;
      end else begin
         if (bus.new_sample_ready) begin
            r_prev_sample <= bus.new_sample_in;
         end
         r_write_enable <= w_store;
         r_capture_done <= w_swap;
         if (w_trigger) begin
            r_index <= 8'd0;
         end else if (w_store) begin
            r_index <= r_index + 8'd1;
         end
         if (w_store) begin
            r_write_address <= {~r_read_index, r_index};
            r_write_sample  <= w_offset_sample;
         end
         if (w_swap) begin
            r_read_index <= ~r_read_index;
         end
      end
   end

   assign bus.write_address = r_write_address;
   assign bus.write_enable  = r_write_enable;
   assign bus.write_sample  = r_write_sample;
   assign bus.read_index    = r_read_index;
   assign bus.capture_done  = r_capture_done;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_capture
// Brief    : Directed and random sample streams checked against a
//            sample-level reference model of the capture rules.
// Revision : 1.0
// ============================================================================
module tb_wave_capture;

   logic clk;
   logic reset;
   wave_capture_if bus ();

   wave_capture dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [16:0] got_q[$];
   logic [16:0] exp_q[$];
   int          done_seen = 0;

   // model: 0 = waiting for crossing, 1 = capturing, 2 = full, awaiting idle
   int   m_mode  = 0;
   int   m_count = 0;
   int   m_prev  = 0;
   int   m_phase = 0;
   logic m_bank  = 1'b0;
   int   m_done  = 0;
   logic idle_level = 1'b0;

   always @(negedge clk) begin
      if (bus.write_enable === 1'b1) got_q.push_back({bus.write_address, bus.write_sample});
      if (bus.capture_done === 1'b1) done_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic model_swap();
      if (m_mode == 2) begin
         m_mode = 0;
         m_bank = ~m_bank;
         m_done++;
      end
   endtask

   task automatic model_sample(input logic [15:0] s);
      int v;
      int stored;
      v = int'($signed(s));
      if (m_mode == 1) begin
         stored = 1;
`ifdef WAVE_CAPTURE_DECIMATE_EN
         stored = (m_phase == 0) ? 1 : 0;
         m_phase = 1 - m_phase;
`endif
         if (stored == 1) begin
            exp_q.push_back({~m_bank, 8'(m_count), 8'((v + 32768) >> 8)});
            m_count++;
            if (m_count == 256) m_mode = 2;
         end
      end else if (m_mode == 0 && m_prev < 0 && v >= 0) begin
         m_mode  = 1;
         m_count = 0;
         m_phase = 0;
      end
      m_prev = v;
      if (idle_level) model_swap();
   endtask

   task automatic feed(input logic [15:0] s);
      @(posedge clk); #1;
      bus.new_sample_ready = 1'b1;
      bus.new_sample_in    = s;
      @(posedge clk); #1;
      bus.new_sample_ready = 1'b0;
      model_sample(s);
   endtask

   task automatic idle_pulse();
      @(posedge clk); #1;
      bus.wave_display_idle = 1'b1;
      @(posedge clk); #1;
      bus.wave_display_idle = 1'b0;
      model_swap();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset   = 1'b0;
      m_mode  = 0;
      m_count = 0;
      m_prev  = 0;
      m_phase = 0;
      m_bank  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int n;
      @(negedge clk); #1;
      chk({tag, "_write_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_write"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
      chk({tag, "_read_index"}, bus.read_index, m_bank);
      chk({tag, "_capture_done_count"}, done_seen, m_done);
   endtask

   initial begin
      reset                 = 1'b1;
      bus.new_sample_ready  = 1'b0;
      bus.new_sample_in     = 16'd0;
      bus.wave_display_idle = 1'b0;
      do_reset();
      chk("reset_write_enable", bus.write_enable, 1'b0);
      chk("reset_write_address", bus.write_address, 9'h000);
      chk("reset_write_sample", bus.write_sample, 8'h00);
      chk("reset_read_index", bus.read_index, 1'b0);
      chk("reset_capture_done", bus.capture_done, 1'b0);

      // crossing -5 -> +3, then the first stored sample
      feed(16'hFFFB);
      feed(16'h0003);
      feed(16'h1234);
      chk("first_write_enable", bus.write_enable, 1'b1);
      chk("first_write_address", bus.write_address, 9'h100);
      chk("first_write_sample", bus.write_sample, 8'h92);
      @(posedge clk); #1;
      chk("first_write_enable_drop", bus.write_enable, 1'b0);

      // fill the rest of the bank with full-scale negative, plus one extra
      for (int i = 0; i < 256; i++) feed(16'h8000);
      check_all("fill");

      idle_pulse();
      chk("swap_read_index", bus.read_index, 1'b1);
      check_all("swap");

      // second capture into bank 0, aborted by reset after 100 stores
      feed(16'hC000);
      feed(16'h0100);
      for (int i = 0; i < 100; i++) feed(16'($urandom));
      check_all("abort_pre");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_write_enable", bus.write_enable, 1'b0);
      chk("abort_read_index", bus.read_index, 1'b0);
      reset   = 1'b0;
      m_mode  = 0;
      m_count = 0;
      m_prev  = 0;
      m_phase = 0;
      m_bank  = 1'b0;
      feed(16'h0001);
      feed(16'h0002);
      idle_pulse();
      check_all("after_abort");

      // idle held high throughout a full capture
      bus.wave_display_idle = 1'b1;
      idle_level = 1'b1;
      feed(16'hFFFF);
      feed(16'h0001);
      for (int i = 0; i < 256; i++) feed(16'($urandom));
      feed(16'h7FFF);
      bus.wave_display_idle = 1'b0;
      idle_level = 1'b0;
      check_all("idle_held");

      // random soak with random idle pulses
      for (int blk = 0; blk < 6; blk++) begin
         for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) idle_pulse();
            else feed(16'($urandom));
         end
         check_all("soak");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on clk.
REQ-003 SHALL have port new_sample_ready, input, 1, one-cycle strobe qualifying new_sample_in.
REQ-004 SHALL have port new_sample_in, input, 16, signed two's-complement audio sample.
REQ-005 SHALL have port wave_display_idle, input, 1, high while display is outside active raster and may swap banks.
REQ-006 SHALL have port write_address, output, 9, sample RAM write address {bank, index[7:0]}.
REQ-007 SHALL have port write_enable, output, 1, sample RAM write strobe.
REQ-008 SHALL have port write_sample, output, 8, unsigned offset-binary sample to store.
REQ-009 SHALL have port read_index, output, 1, bank currently owned by display; capture writes the other bank.
REQ-010 SHALL have port capture_done, output, 1, one-cycle pulse on bank swap.

Function
REQ-011 SHALL implement states ARMED, ACTIVE, WAIT; reset state ARMED.
REQ-012 SHALL register prev_sample on every new_sample_ready, all states; reset value 0.
REQ-013 ARMED: SHALL go to ACTIVE, index=0, on new_sample_ready with prev_sample[15]=1 and new_sample_in[15]=0 (positive zero crossing); otherwise stay.
REQ-014 The triggering sample SHALL NOT be stored; storage starts with the next new_sample_ready.
REQ-015 ACTIVE: each stored sample SHALL produce write_enable=1 for exactly one cycle, the cycle after the new_sample_ready strobe.
REQ-016 write_address SHALL be {~read_index, index[7:0]}; write_sample SHALL be {~new_sample_in[15], new_sample_in[14:8]}; both registered with write_enable.
REQ-017 index SHALL increment after each stored sample; storing index 255 SHALL move to WAIT, index wraps to 0.
REQ-018 WAIT: new_sample_ready SHALL store nothing; on wave_display_idle=1, read_index SHALL toggle, capture_done SHALL pulse the next cycle, state SHALL return to ARMED.
REQ-019 wave_display_idle SHALL be ignored in ARMED and ACTIVE; idle coincident with the 255th store SHALL NOT swap that cycle; swap occurs at earliest idle cycle seen in WAIT.
REQ-020 write_enable SHALL be 0 in ARMED and WAIT and on all non-strobe cycles.
REQ-021 Exactly 256 writes SHALL occur between consecutive capture_done pulses (macro off).

Reset
REQ-022 Reset SHALL set state=ARMED, index=0, prev_sample=0, read_index=0, write_enable=0, write_address=0, write_sample=0, capture_done=0.
REQ-023 Reset mid-ACTIVE or mid-WAIT SHALL abort capture with no further writes and no swap; reset has priority over all inputs.
REQ-024 After reset release, first sample SHALL NOT trigger (prev_sample=0 non-negative).

Configuration
REQ-025 Macro WAVE_CAPTURE_DECIMATE_EN SHALL, when defined, add a 1-bit phase cleared on entering ACTIVE and toggled on each ACTIVE new_sample_ready; only phase=0 strobes store, so 512 strobes fill 256 entries.
REQ-026 Without WAVE_CAPTURE_DECIMATE_EN, no phase logic SHALL exist and every ACTIVE strobe stores.

Verification
REQ-027 Reset, samples -5, +3 -> ACTIVE after +3; next strobe sample 0x1234 -> write_enable next cycle, write_address=0x100, write_sample=0x92.
REQ-028 Trigger then 256 strobes of 0x8000 -> 256 writes, addresses 0x100..0x1FF, write_sample=0x00, then WAIT, no write on strobe 257.
REQ-029 In WAIT assert wave_display_idle -> read_index 0->1, capture_done one pulse; next capture writes 0x000..0x0FF.
REQ-030 Reset asserted after 100 stored samples -> write_enable=0 next cycle, read_index=0, ARMED; samples +1,+2 -> no trigger.
REQ-031 Idle held high during ACTIVE and at 255th store -> swap only in the cycle after WAIT entry, single capture_done.
REQ-032 With WAVE_CAPTURE_DECIMATE_EN: trigger, 512 strobes -> 256 writes from even strobes 0,2,4..., then WAIT.
